// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master, one-slave arbiter for the 32-bit memory bus.
//   Master 0 is instruction fetch and master 1 is load/store. Grants alternate
//   round-robin on ties. A registered owner drives the slave combinationally,
//   and a bus watchdog force-completes stalled transfers and reports a fault.
//
// Ports:
//   clk, reset                 bus clock, asynchronous active-low reset
//   m{0,1}_address_in          master byte address
//   m{0,1}_sel_in              master request, held until ready is seen
//   m{0,1}_write_mask_in       byte-lane write enables
//   m{0,1}_write_value_in      write data
//   m{0,1}_read_value_out      read data, 0 unless this master owns the bus
//   m{0,1}_ready_out           transfer complete for this master
//   s_*                        slave side of the bus
//   grant_out                  one-hot owner, 00 when idle
//   fault_out                  one-cycle pulse on watchdog termination
//   fault_address_out          address of the last timed-out transfer
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_WIDTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_address_in,
    input  logic        m0_sel_in,
    output logic [31:0] m0_read_value_out,
    input  logic [3:0]  m0_write_mask_in,
    input  logic [31:0] m0_write_value_in,
    output logic        m0_ready_out,
    input  logic [31:0] m1_address_in,
    input  logic        m1_sel_in,
    output logic [31:0] m1_read_value_out,
    input  logic [3:0]  m1_write_mask_in,
    input  logic [31:0] m1_write_value_in,
    output logic        m1_ready_out,
    output logic [31:0] s_address_out,
    output logic        s_sel_out,
    input  logic [31:0] s_read_value_in,
    output logic [3:0]  s_write_mask_out,
    output logic [31:0] s_write_value_out,
    input  logic        s_ready_in,
    output logic [1:0]  grant_out,
    output logic        fault_out,
    output logic [31:0] fault_address_out
);

    typedef enum logic {StIdle, StBusy} state_e;

    localparam bit WdogEn = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] WdogLast = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e                   state_q, state_d;
    logic                     owner_q, owner_d;           // 0 = master 0, 1 = master 1
    logic                     last_owner_q, last_owner_d;
    logic [TIMEOUT_WIDTH-1:0] wdog_q, wdog_d;
    logic [31:0]              fault_addr_q, fault_addr_d;

    logic        busy;
    logic        own_sel, oth_sel;
    logic [31:0] own_addr, own_wval;
    logic [3:0]  own_mask;
    logic        timeout, complete;
    logic [31:0] rdata;

    always_comb begin
        busy     = (state_q == StBusy);
        own_sel  = owner_q ? m1_sel_in : m0_sel_in;
        oth_sel  = owner_q ? m0_sel_in : m1_sel_in;
        own_addr = owner_q ? m1_address_in : m0_address_in;
        own_wval = owner_q ? m1_write_value_in : m0_write_value_in;
        own_mask = owner_q ? m1_write_mask_in : m0_write_mask_in;
        // Ready on the last allowed cycle beats the watchdog.
        timeout  = WdogEn && busy && own_sel && (wdog_q == WdogLast) && !s_ready_in;
        complete = busy && own_sel && (s_ready_in || timeout);
        rdata    = timeout ? 32'h0 : s_read_value_in;
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        wdog_d       = wdog_q;
        fault_addr_d = fault_addr_q;
        unique case (state_q)
            StIdle: begin
                if (m0_sel_in || m1_sel_in) begin
                    state_d = StBusy;
                    wdog_d  = '0;
                    if (m0_sel_in && m1_sel_in) begin
                        owner_d = ~last_owner_q;
                    end else begin
                        owner_d = m1_sel_in;
                    end
                end
            end
            StBusy: begin
                if (!own_sel) begin
                    // Abort: owner withdrew before completion.
                    state_d = StIdle;
                end else if (complete) begin
                    last_owner_d = owner_q;
                    if (oth_sel) begin
                        // Back-to-back hand-over, no idle cycle.
                        owner_d = ~owner_q;
                        wdog_d  = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
                if (timeout) begin
                    fault_addr_d = own_addr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b0;
            wdog_q       <= '0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            wdog_q       <= wdog_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    // Outputs: everything is gated by busy, so reset clears them at once.
    always_comb begin
        s_sel_out         = busy && own_sel && !timeout;  // timed-out write never lands
        s_address_out     = busy ? own_addr : 32'h0;
        s_write_mask_out  = busy ? own_mask : 4'h0;
        s_write_value_out = busy ? own_wval : 32'h0;
        m0_ready_out      = busy && !owner_q && (s_ready_in || timeout);
        m1_ready_out      = busy && owner_q && (s_ready_in || timeout);
        m0_read_value_out = (busy && !owner_q) ? rdata : 32'h0;
        m1_read_value_out = (busy && owner_q) ? rdata : 32'h0;
        grant_out         = busy ? {owner_q, ~owner_q} : 2'b00;
        fault_out         = timeout;
        fault_address_out = fault_addr_q;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by two randomised
// masters. A memory-backed slave with address-dependent wait states sits on
// the bus; expected responses are queued per master at issue time and popped
// by an independent monitor whenever a ready appears.
module tb_mem_bus_arbiter;

    localparam int unsigned Tmo = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_addr [2];
    logic        m_sel  [2];
    logic [3:0]  m_mask [2];
    logic [31:0] m_wval [2];
    logic [31:0] m0_rv, m1_rv;
    logic        m0_rdy, m1_rdy;
    logic [31:0] s_addr, s_wval, s_rval;
    logic        s_sel, s_rdy;
    logic [3:0]  s_mask;
    logic [1:0]  grant;
    logic        fault;
    logic [31:0] fault_addr;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES(Tmo),
        .TIMEOUT_WIDTH (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address_in    (m_addr[0]),
        .m0_sel_in        (m_sel[0]),
        .m0_read_value_out(m0_rv),
        .m0_write_mask_in (m_mask[0]),
        .m0_write_value_in(m_wval[0]),
        .m0_ready_out     (m0_rdy),
        .m1_address_in    (m_addr[1]),
        .m1_sel_in        (m_sel[1]),
        .m1_read_value_out(m1_rv),
        .m1_write_mask_in (m_mask[1]),
        .m1_write_value_in(m_wval[1]),
        .m1_ready_out     (m1_rdy),
        .s_address_out    (s_addr),
        .s_sel_out        (s_sel),
        .s_read_value_in  (s_rval),
        .s_write_mask_out (s_mask),
        .s_write_value_out(s_wval),
        .s_ready_in       (s_rdy),
        .grant_out        (grant),
        .fault_out        (fault),
        .fault_address_out(fault_addr)
    );

    // ---------------- slave model ----------------
    logic [31:0] slave_mem [1024];
    int unsigned wait_cnt;
    bit          stall;

    // Wait states before ready: 0..3 normally, 6 for word offsets 7 mod 8.
    function automatic int unsigned slave_wait(input logic [31:0] a);
        return (a[4:2] == 3'd7) ? 32'd6 : {30'd0, a[3:2]};
    endfunction

    function automatic logic [31:0] init_val(input int i);
        return (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    always_comb begin
        s_rdy  = s_sel && !stall && (wait_cnt == slave_wait(s_addr));
        s_rval = s_rdy ? slave_mem[s_addr[11:2]] : 32'hBAD0_BAD0;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) wait_cnt <= 0;
        else if (s_sel && !s_rdy) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    always @(posedge clk) begin
        if (reset && s_sel && s_rdy) begin
            for (int b = 0; b < 4; b++) begin
                if (s_mask[b]) slave_mem[s_addr[11:2]][8*b +: 8] <= s_wval[8*b +: 8];
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [31:0] data;
        bit          fault;
        logic [31:0] addr;
    } exp_t;

    logic [31:0] ref_mem [1024];
    exp_t        exp_q0 [$];
    exp_t        exp_q1 [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          pend_fa = 1'b0;
    logic [31:0] pend_fa_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic req);
        check(name, {31'd0, act}, {31'd0, req});
    endtask

    // A transfer faults when the slave would answer later than the watchdog allows.
    task automatic issue(input int m, input logic [31:0] a, input logic [3:0] mk,
                         input logic [31:0] wd);
        exp_t        e;
        int unsigned i;
        i       = {22'd0, a[11:2]};
        e.addr  = a;
        e.fault = stall || (slave_wait(a) >= Tmo);
        e.data  = e.fault ? 32'h0 : ref_mem[i];
        if (!e.fault) begin
            for (int b = 0; b < 4; b++) if (mk[b]) ref_mem[i][8*b +: 8] = wd[8*b +: 8];
        end
        if (m == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
        m_addr[m] = a;
        m_mask[m] = mk;
        m_wval[m] = wd;
        m_sel[m]  = 1'b1;
    endtask

    task automatic wait_done(input int m);
        int   n;
        logic r;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            r = (m == 0) ? m0_rdy : m1_rdy;
        end while (!r && n < 40);
        check_b($sformatf("m%0d_done_in_bound", m), r, 1'b1);
        @(posedge clk);
        #1;
        m_sel[m] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic run_master(input int m);
        for (int t = 0; t < 60; t++) begin
            int          gap;
            logic [31:0] a;
            logic [3:0]  mk;
            logic [31:0] wd;
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            a  = (m == 0) ? 32'h0 : 32'h100;
            a  = a + ($urandom_range(0, 63) << 2);
            mk = (m == 1 && $urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            wd = $urandom;
            issue(m, a, mk, wd);
            wait_done(m);
        end
    endtask

    // Monitor: pops an expectation whenever a master sees ready.
    always @(negedge clk) begin
        exp_t        e;
        bit          exp_fault;
        logic        rdy;
        logic [31:0] rv;
        logic [1:0]  own_g;
        int          qs;
        if (reset !== 1'b1) begin
            exp_q0.delete();
            exp_q1.delete();
            pend_fa = 1'b0;
        end else begin
            exp_fault = 1'b0;
            if (pend_fa) begin
                check("fault_address", fault_addr, pend_fa_addr);
                pend_fa = 1'b0;
            end
            check_b("grant_not_both", grant == 2'b11, 1'b0);
            for (int m = 0; m < 2; m++) begin
                rdy   = (m == 0) ? m0_rdy : m1_rdy;
                rv    = (m == 0) ? m0_rv : m1_rv;
                own_g = (m == 0) ? 2'b01 : 2'b10;
                qs    = (m == 0) ? exp_q0.size() : exp_q1.size();
                if (grant != own_g) check($sformatf("m%0d_nonowner_rdata", m), rv, 32'h0);
                if (rdy) begin
                    check($sformatf("m%0d_ready_owner", m), {30'd0, grant}, {30'd0, own_g});
                    if (qs == 0) begin
                        check_b($sformatf("m%0d_unexpected_ready", m), rdy, 1'b0);
                    end else begin
                        if (m == 0) e = exp_q0.pop_front();
                        else e = exp_q1.pop_front();
                        check($sformatf("m%0d_rdata@%h", m, e.addr), rv, e.data);
                        if (e.fault) begin
                            exp_fault    = 1'b1;
                            pend_fa      = 1'b1;
                            pend_fa_addr = e.addr;
                        end
                    end
                end
            end
            check_b("fault_out", fault, exp_fault);
        end
    end

    // ---------------- directed sequence, then random ----------------
    initial begin
        reset = 1'b0;
        stall = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_addr[m] = '0;
            m_sel[m]  = 1'b0;
            m_mask[m] = '0;
            m_wval[m] = '0;
        end
        for (int i = 0; i < 1024; i++) begin
            slave_mem[i] = init_val(i);
            ref_mem[i]   = init_val(i);
        end
        slave_mem[64] = 32'hDEAD_BEEF;
        ref_mem[64]   = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Idle after reset
        repeat (10) begin
            @(negedge clk);
            check("idle_grant", {30'd0, grant}, 32'd0);
            check_b("idle_s_sel", s_sel, 1'b0);
            check_b("idle_fault", fault, 1'b0);
            check_b("idle_m0_rdy", m0_rdy, 1'b0);
            check_b("idle_m1_rdy", m1_rdy, 1'b0);
        end
        check("reset_fault_addr", fault_addr, 32'h0);

        // Master 0 alone, zero-wait read
        @(posedge clk);
        #1 issue(0, 32'h100, 4'h0, 32'h0);
        @(negedge clk);
        check("zw_idle_grant", {30'd0, grant}, 32'd0);
        @(negedge clk);
        check("zw_grant", {30'd0, grant}, 32'd1);
        check_b("zw_ready", m0_rdy, 1'b1);
        check("zw_data", m0_rv, 32'hDEAD_BEEF);
        check("zw_m1_rv", m1_rv, 32'h0);
        @(posedge clk);
        #1 m_sel[0] = 1'b0;

        // Tie from reset: master 1 first, then master 0 back-to-back
        do_reset();
        @(posedge clk);
        #1;
        issue(1, 32'h200, 4'hF, 32'h1234_5678);
        issue(0, 32'h100, 4'h0, 32'h0);
        @(negedge clk);
        check("tie_idle_grant", {30'd0, grant}, 32'd0);
        @(negedge clk);
        check("tie_grant_m1", {30'd0, grant}, 32'd2);
        check_b("tie_s_sel", s_sel, 1'b1);
        check("tie_s_addr", s_addr, 32'h200);
        check("tie_s_mask", {28'd0, s_mask}, 32'hF);
        check("tie_s_wval", s_wval, 32'h1234_5678);
        check_b("tie_m1_rdy", m1_rdy, 1'b1);
        @(posedge clk);
        #1 m_sel[1] = 1'b0;
        @(negedge clk);
        check("tie_b2b_grant_m0", {30'd0, grant}, 32'd1);
        check_b("tie_b2b_m0_rdy", m0_rdy, 1'b1);
        @(posedge clk);
        #1 m_sel[0] = 1'b0;
        @(negedge clk);
        check("tie_slave_wrote", slave_mem[128], 32'h1234_5678);

        // Master 1 owns last, then a tie goes to master 0
        @(posedge clk);
        #1 issue(1, 32'h104, 4'h0, 32'h0);
        wait_done(1);
        issue(1, 32'h108, 4'h0, 32'h0);
        issue(0, 32'h100, 4'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("tie2_grant_m0", {30'd0, grant}, 32'd1);
        @(posedge clk);
        #1 m_sel[0] = 1'b0;
        @(negedge clk);
        check("tie2_grant_m1", {30'd0, grant}, 32'd2);
        wait_done(1);

        // Watchdog: slave never ready
        stall = 1'b1;
        issue(1, 32'h3000, 4'h0, 32'h0);
        @(negedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check_b($sformatf("to_m1_rdy_c%0d", c), m1_rdy, c == 4);
            check_b($sformatf("to_fault_c%0d", c), fault, c == 4);
            check_b($sformatf("to_s_sel_c%0d", c), s_sel, c != 4);
        end
        check("to_m1_rv", m1_rv, 32'h0);
        @(posedge clk);
        #1;
        m_sel[1] = 1'b0;
        stall    = 1'b0;
        @(negedge clk);
        check("to_fault_addr", fault_addr, 32'h3000);
        check_b("to_fault_cleared", fault, 1'b0);

        // Ready arrives exactly on the last watchdog cycle
        @(posedge clk);
        #1 issue(0, 32'h00C, 4'h0, 32'h0);
        @(negedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check_b($sformatf("edge_m0_rdy_c%0d", c), m0_rdy, c == 4);
            check_b($sformatf("edge_fault_c%0d", c), fault, 1'b0);
        end
        check("edge_m0_rv", m0_rv, init_val(3));
        @(posedge clk);
        #1 m_sel[0] = 1'b0;

        // Reset while master 0 is stalled
        stall = 1'b1;
        @(posedge clk);
        #1 issue(0, 32'h010, 4'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_busy_grant", {30'd0, grant}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_async_grant", {30'd0, grant}, 32'd0);
        check_b("rst_async_m0_rdy", m0_rdy, 1'b0);
        check_b("rst_async_s_sel", s_sel, 1'b0);
        m_sel[0] = 1'b0;
        stall    = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 issue(0, 32'h100, 4'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("rst_after_grant", {30'd0, grant}, 32'd1);
        check_b("rst_after_m0_rdy", m0_rdy, 1'b1);
        @(posedge clk);
        #1 m_sel[0] = 1'b0;

        // Random traffic from both masters
        fork
            run_master(0);
            run_master(1);
        join
        repeat (5) @(negedge clk);
        check("q0_drained", exp_q0.size(), 32'd0);
        check("q1_drained", exp_q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "simulation time limit");
    end

endmodule
